// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: shift-add multiply and restoring divide on
// operand magnitudes, with sign fix-up applied when the result is written back.
module muldiv_unit #(
    parameter int XLEN            = 32,
    parameter int STEPS_PER_CYCLE = 1,
    parameter int REG_ADDR_W      = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  valid_In,
    input  logic [2:0]            opCode_In,
    input  logic [XLEN-1:0]       resource1_In,
    input  logic [XLEN-1:0]       resource2_In,
    input  logic [REG_ADDR_W-1:0] rdAddr_In,
    input  logic                  flush_In,
    output logic                  ready_Out,
    output logic                  execLockSet_Out,
    output logic [REG_ADDR_W-1:0] rdAddr_Out,
    output logic [XLEN-1:0]       rdWrite_Out,
    output logic                  rdEnable_Out
);
    localparam int ITER  = XLEN / STEPS_PER_CYCLE;
    localparam int CNT_W = $clog2(ITER + 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t state_reg, state_next;

    logic [2:0]            op_reg;
    logic [REG_ADDR_W-1:0] rd_addr_reg;
    logic [XLEN-1:0]       operand_reg;
    logic [2*XLEN-1:0]     acc_reg;
    logic                  neg_res_reg, neg_rem_reg, special_reg;
    logic [CNT_W-1:0]      count_reg;

    // Operand decode at accept time
    logic            accept;
    logic            is_div_in, rs1_signed, rs2_signed, rs1_neg, rs2_neg;
    logic            div_zero, div_ovf, special_in;
    logic [XLEN-1:0] rs1_mag, rs2_mag, special_val;

    assign accept     = valid_In & (state_reg == IDLE) & ~flush_In & ~rst;
    assign is_div_in  = opCode_In[2];
    assign rs1_signed = (opCode_In != 3'd3) && !(opCode_In[2] && opCode_In[0]);
    assign rs2_signed = (opCode_In != 3'd2) && (opCode_In != 3'd3) && !(opCode_In[2] && opCode_In[0]);
    assign rs1_neg    = rs1_signed & resource1_In[XLEN-1];
    assign rs2_neg    = rs2_signed & resource2_In[XLEN-1];
    assign rs1_mag    = rs1_neg ? -resource1_In : resource1_In;
    assign rs2_mag    = rs2_neg ? -resource2_In : resource2_In;
    assign div_zero   = is_div_in && (resource2_In == '0);
    assign div_ovf    = is_div_in && !opCode_In[0] && (resource1_In == {1'b1, {(XLEN-1){1'b0}}})
                        && (&resource2_In);
    assign special_in = div_zero | div_ovf;

    always_comb begin
        special_val = '0;
        if (div_zero)
            special_val = opCode_In[1] ? resource1_In : '1;
        else if (div_ovf)
            special_val = opCode_In[1] ? '0 : resource1_In;
    end

    // Unrolled iteration chain: STEPS_PER_CYCLE bits per clock
    logic [STEPS_PER_CYCLE:0][2*XLEN-1:0] stage;
    assign stage[0] = acc_reg;

    generate
        for (genvar gi = 0; gi < STEPS_PER_CYCLE; gi++) begin : g_step
            logic [XLEN:0]     mul_sum, rem_ext;
            logic [XLEN-1:0]   rem_diff;
            logic              fits;
            logic [2*XLEN-1:0] mul_next, div_next;

            assign mul_sum  = {1'b0, stage[gi][2*XLEN-1:XLEN]}
                              + (stage[gi][0] ? {1'b0, operand_reg} : {(XLEN+1){1'b0}});
            assign mul_next = {mul_sum, stage[gi][XLEN-1:1]};
            // Partial remainder is below 2*divisor, so the true difference fits in XLEN bits
            assign rem_ext  = {stage[gi][2*XLEN-1:XLEN], stage[gi][XLEN-1]};
            assign fits     = rem_ext >= {1'b0, operand_reg};
            assign rem_diff = rem_ext[XLEN-1:0] - operand_reg;
            assign div_next = fits ? {rem_diff, stage[gi][XLEN-2:0], 1'b1}
                                   : {rem_ext[XLEN-1:0], stage[gi][XLEN-2:0], 1'b0};
            assign stage[gi+1] = op_reg[2] ? div_next : mul_next;
        end
    endgenerate

    // Final result with sign fix-up
    logic [2*XLEN-1:0] prod_signed;
    logic [XLEN-1:0]   quot_mag, rem_mag, result;

    assign prod_signed = neg_res_reg ? -acc_reg : acc_reg;
    assign quot_mag    = acc_reg[XLEN-1:0];
    assign rem_mag     = acc_reg[2*XLEN-1:XLEN];

    always_comb begin
        result = '0;
        if (special_reg)
            result = acc_reg[XLEN-1:0];
        else begin
            case (op_reg)
                3'd0:             result = prod_signed[XLEN-1:0];
                3'd1, 3'd2, 3'd3: result = prod_signed[2*XLEN-1:XLEN];
                3'd4, 3'd5:       result = neg_res_reg ? -quot_mag : quot_mag;
                default:          result = neg_rem_reg ? -rem_mag : rem_mag;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst)
            state_reg <= IDLE;
        else
            state_reg <= state_next;
    end

    always_comb begin
        state_next      = state_reg;
        ready_Out       = 1'b0;
        execLockSet_Out = 1'b0;
        rdEnable_Out    = 1'b0;
        rdWrite_Out     = '0;
        rdAddr_Out      = '0;
        if (!rst) begin
            rdAddr_Out = rd_addr_reg;
            case (state_reg)
                IDLE: begin
                    ready_Out = 1'b1;
                    if (valid_In && !flush_In)
                        state_next = special_in ? DONE : RUN;
                end
                RUN: begin
                    execLockSet_Out = 1'b1;
                    if (flush_In)
                        state_next = IDLE;
                    else if (count_reg == CNT_W'(1))
                        state_next = DONE;
                end
                DONE: begin
                    execLockSet_Out = 1'b1;
                    state_next      = IDLE;
                    if (!flush_In) begin
                        rdEnable_Out = 1'b1;
                        rdWrite_Out  = result;
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            op_reg      <= '0;
            rd_addr_reg <= '0;
            operand_reg <= '0;
            acc_reg     <= '0;
            neg_res_reg <= 1'b0;
            neg_rem_reg <= 1'b0;
            special_reg <= 1'b0;
            count_reg   <= '0;
        end else if (accept) begin
            op_reg      <= opCode_In;
            rd_addr_reg <= rdAddr_In;
            neg_res_reg <= rs1_neg ^ rs2_neg;
            neg_rem_reg <= rs1_neg;
            special_reg <= special_in;
            count_reg   <= CNT_W'(ITER);
            if (special_in) begin
                acc_reg     <= {{XLEN{1'b0}}, special_val};
                operand_reg <= '0;
            end else if (is_div_in) begin
                acc_reg     <= {{XLEN{1'b0}}, rs1_mag};
                operand_reg <= rs2_mag;
            end else begin
                acc_reg     <= {{XLEN{1'b0}}, rs2_mag};
                operand_reg <= rs1_mag;
            end
        end else if (state_reg == RUN) begin
            acc_reg   <= stage[STEPS_PER_CYCLE];
            count_reg <= count_reg - CNT_W'(1);
        end
    end
endmodule

// File: tb/tb_muldiv_unit.sv
// Bench for muldiv_unit: directed vector table, hand-written flush/reset sequences,
// and random operations checked against a 64-bit arithmetic reference model.
module tb_muldiv_unit;
    localparam logic [31:0] MIN = 32'h8000_0000;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, flush, valid0, valid4;
    logic [2:0]  op;
    logic [31:0] a, b;
    logic [4:0]  rd;

    logic        ready0, lock0, rden0, ready4, lock4, rden4;
    logic [4:0]  rdaddr0, rdaddr4;
    logic [31:0] rdwrite0, rdwrite4;

    muldiv_unit #(.XLEN(32), .STEPS_PER_CYCLE(1), .REG_ADDR_W(5)) dut (
        .clk(clk), .rst(rst), .valid_In(valid0), .opCode_In(op),
        .resource1_In(a), .resource2_In(b), .rdAddr_In(rd), .flush_In(flush),
        .ready_Out(ready0), .execLockSet_Out(lock0), .rdAddr_Out(rdaddr0),
        .rdWrite_Out(rdwrite0), .rdEnable_Out(rden0)
    );

    muldiv_unit #(.XLEN(32), .STEPS_PER_CYCLE(4), .REG_ADDR_W(5)) dut4 (
        .clk(clk), .rst(rst), .valid_In(valid4), .opCode_In(op),
        .resource1_In(a), .resource2_In(b), .rdAddr_In(rd), .flush_In(flush),
        .ready_Out(ready4), .execLockSet_Out(lock4), .rdAddr_Out(rdaddr4),
        .rdWrite_Out(rdwrite4), .rdEnable_Out(rden4)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h", name, got, exp);
        end
    endtask

    // Reference model: RV32M semantics via 64-bit arithmetic
    function automatic logic [31:0] model(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        logic signed [63:0] sx, sy, ux, uy, p;
        sx = {{32{x[31]}}, x};
        sy = {{32{y[31]}}, y};
        ux = {32'b0, x};
        uy = {32'b0, y};
        p  = '0;
        case (o)
            3'd0: begin p = sx * sy; return p[31:0]; end
            3'd1: begin p = sx * sy; return p[63:32]; end
            3'd2: begin p = sx * uy; return p[63:32]; end
            3'd3: begin p = ux * uy; return p[63:32]; end
            3'd4: begin
                if (y == 0) return 32'hFFFF_FFFF;
                if (x == MIN && y == 32'hFFFF_FFFF) return x;
                p = sx / sy; return p[31:0];
            end
            3'd5: begin
                if (y == 0) return 32'hFFFF_FFFF;
                p = ux / uy; return p[31:0];
            end
            3'd6: begin
                if (y == 0) return x;
                if (x == MIN && y == 32'hFFFF_FFFF) return 32'h0;
                p = sx % sy; return p[31:0];
            end
            default: begin
                if (y == 0) return x;
                p = ux % uy; return p[31:0];
            end
        endcase
    endfunction

    function automatic bit is_special(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        return o[2] && (y == 0 || ((o == 3'd4 || o == 3'd6) && x == MIN && y == 32'hFFFF_FFFF));
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0: return 32'h0;
            1: return 32'h1;
            2: return 32'hFFFF_FFFF;
            3: return MIN;
            4: return 32'h7FFF_FFFF;
            5: return 32'($urandom_range(0, 15));
            default: return $urandom;
        endcase
    endfunction

    // Issue one op to the selected unit, wait for its write-back pulse, check address and pulse width
    task automatic run_op(input bit sel, input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                          input logic [4:0] r, output logic [31:0] res, output int lat);
        @(negedge clk);
        op = o; a = x; b = y; rd = r;
        if (sel) valid4 = 1'b1; else valid0 = 1'b1;
        @(posedge clk);
        #1;
        valid0 = 1'b0; valid4 = 1'b0;
        a = $urandom; b = $urandom; op = 3'($urandom); rd = 5'($urandom);
        lat = 1;
        while (!(sel ? rden4 : rden0) && lat < 200) begin
            @(posedge clk);
            #1;
            lat++;
        end
        if (!(sel ? rden4 : rden0)) begin
            n_checks++;
            n_errors++;
            $display("FAIL timeout: no rdEnable_Out after %0d cycles, required a pulse", lat);
        end
        res = sel ? rdwrite4 : rdwrite0;
        chk("rd_addr", 32'(sel ? rdaddr4 : rdaddr0), 32'(r));
        @(posedge clk);
        #1;
        chk("pulse_width", 32'(sel ? rden4 : rden0), 32'd0);
        chk("rdwrite_idle", sel ? rdwrite4 : rdwrite0, 32'd0);
        chk("ready_after", 32'(sel ? ready4 : ready0), 32'd1);
    endtask

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        int          lat;
    } vec_t;

    vec_t        vecs[15];
    logic [31:0] res, ra, rb;
    logic [2:0]  ro;
    int          lat, exp_lat;
    bit          seen, sel;

    initial begin
        vecs[0]  = '{3'd0, 32'd7,         32'hFFFF_FFFD, 32'hFFFF_FFEB, 33};
        vecs[1]  = '{3'd1, MIN,           MIN,           32'h4000_0000, 33};
        vecs[2]  = '{3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33};
        vecs[3]  = '{3'd2, 32'hFFFF_FFFF, 32'd2,         32'hFFFF_FFFF, 33};
        vecs[4]  = '{3'd4, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 33};
        vecs[5]  = '{3'd6, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 33};
        vecs[6]  = '{3'd5, 32'd100,       32'd7,         32'd14,        33};
        vecs[7]  = '{3'd7, 32'd100,       32'd7,         32'd2,         33};
        vecs[8]  = '{3'd5, 32'd5,         32'd0,         32'hFFFF_FFFF, 1};
        vecs[9]  = '{3'd6, 32'd5,         32'd0,         32'd5,         1};
        vecs[10] = '{3'd4, MIN,           32'hFFFF_FFFF, MIN,           1};
        vecs[11] = '{3'd6, MIN,           32'hFFFF_FFFF, 32'd0,         1};
        vecs[12] = '{3'd0, 32'd3,         32'd4,         32'd12,        33};
        vecs[13] = '{3'd4, 32'd7,         32'hFFFF_FFFE, 32'hFFFF_FFFD, 33};
        vecs[14] = '{3'd6, 32'd7,         32'hFFFF_FFFE, 32'd1,         33};

        rst = 1'b1; flush = 1'b0; valid0 = 1'b0; valid4 = 1'b0;
        op = '0; a = '0; b = '0; rd = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready", 32'(ready0), 32'd0);
        chk("rst_lock", 32'(lock0), 32'd0);
        chk("rst_en", 32'(rden0), 32'd0);
        chk("rst_wdata", rdwrite0, 32'd0);
        chk("rst_addr", 32'(rdaddr0), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("idle_ready", 32'(ready0), 32'd1);
        chk("idle_ready4", 32'(ready4), 32'd1);

        for (int i = 0; i < 15; i++) begin
            run_op(1'b0, vecs[i].op, vecs[i].a, vecs[i].b, 5'(i + 1), res, lat);
            $display("vec %0d op=%0d a=%h b=%h res=%h lat=%0d", i, vecs[i].op, vecs[i].a, vecs[i].b, res, lat);
            chk("vec_result", res, vecs[i].exp);
            chk("vec_latency", 32'(lat), 32'(vecs[i].lat));
        end

        run_op(1'b1, 3'd0, 32'd7, 32'hFFFF_FFFD, 5'd9, res, lat);
        $display("steps4 op=0 a=00000007 b=fffffffd res=%h lat=%0d", res, lat);
        chk("steps4_result", res, 32'hFFFF_FFEB);
        chk("steps4_latency", 32'(lat), 32'd9);

        for (int i = 0; i < 40; i++) begin
            sel = i[0];
            ro  = 3'($urandom_range(0, 7));
            ra  = pick();
            rb  = pick();
            exp_lat = is_special(ro, ra, rb) ? 1 : (sel ? 9 : 33);
            run_op(sel, ro, ra, rb, 5'($urandom), res, lat);
            $display("rand %0d unit=%0d op=%0d a=%h b=%h res=%h lat=%0d", i, sel, ro, ra, rb, res, lat);
            chk("rand_result", res, model(ro, ra, rb));
            chk("rand_latency", 32'(lat), 32'(exp_lat));
        end

        // Flush ten cycles into a divide
        @(negedge clk);
        op = 3'd4; a = 32'd100; b = 32'd7; rd = 5'd3; valid0 = 1'b1;
        @(posedge clk);
        #1;
        valid0 = 1'b0;
        seen = 1'b0;
        repeat (9) begin
            @(posedge clk);
            #1;
            if (rden0) seen = 1'b1;
        end
        @(negedge clk);
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        chk("flush_ready", 32'(ready0), 32'd1);
        chk("flush_lock", 32'(lock0), 32'd0);
        repeat (40) begin
            @(posedge clk);
            #1;
            if (rden0) seen = 1'b1;
        end
        $display("flush mid-DIV: pulse_seen=%0d", seen);
        chk("flush_no_pulse", 32'(seen), 32'd0);
        run_op(1'b0, 3'd0, 32'd3, 32'd4, 5'd4, res, lat);
        $display("after flush MUL 3x4 res=%h lat=%0d", res, lat);
        chk("after_flush_mul", res, 32'd12);

        // Flush coinciding with DONE of a special-case op
        @(negedge clk);
        op = 3'd5; a = 32'd5; b = 32'd0; rd = 5'd6; valid0 = 1'b1;
        @(posedge clk);
        #1;
        valid0 = 1'b0;
        flush = 1'b1;
        #1;
        chk("done_flush_en", 32'(rden0), 32'd0);
        chk("done_flush_lock", 32'(lock0), 32'd1);
        @(posedge clk);
        #1;
        flush = 1'b0;
        chk("done_flush_ready", 32'(ready0), 32'd1);
        $display("flush in DONE: en=%0d ready=%0d", rden0, ready0);

        // Flush in IDLE blocks the accept
        @(negedge clk);
        op = 3'd0; a = 32'd3; b = 32'd4; valid0 = 1'b1; flush = 1'b1;
        @(posedge clk);
        #1;
        valid0 = 1'b0; flush = 1'b0;
        $display("flush in IDLE: ready=%0d lock=%0d", ready0, lock0);
        chk("idle_flush_ready", 32'(ready0), 32'd1);
        chk("idle_flush_lock", 32'(lock0), 32'd0);

        // Reset during RUN
        @(negedge clk);
        op = 3'd0; a = 32'd7; b = 32'd9; rd = 5'd7; valid0 = 1'b1;
        @(posedge clk);
        #1;
        valid0 = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("rrun_ready", 32'(ready0), 32'd0);
        chk("rrun_lock", 32'(lock0), 32'd0);
        chk("rrun_addr", 32'(rdaddr0), 32'd0);
        @(posedge clk);
        #1;
        chk("rrun_en", 32'(rden0), 32'd0);
        chk("rrun_wdata", rdwrite0, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rrun_idle_ready", 32'(ready0), 32'd1);
        chk("rrun_idle_lock", 32'(lock0), 32'd0);
        seen = 1'b0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (rden0) seen = 1'b1;
        end
        $display("reset mid-RUN: pulse_seen=%0d", seen);
        chk("rrun_no_pulse", 32'(seen), 32'd0);
        run_op(1'b0, 3'd0, 32'd7, 32'hFFFF_FFFD, 5'd8, res, lat);
        $display("after reset MUL 7x-3 res=%h lat=%0d", res, lat);
        chk("after_rst_mul", res, 32'hFFFF_FFEB);
        chk("after_rst_lat", 32'(lat), 32'd33);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
